aes_sbox_sub: RTL and testbench

Registered AES forward S-box (SubBytes) stage working on a NO_ROWS x NO_COLS byte state matrix. The encryption core asserts the enable, waits for the valid flag, then drops the enable. Row and column masks select which bytes are substituted; all other bytes pass through unchanged. Sits between the AddRoundKey result and the ShiftRows/MixColumns logic in the encryption core.

---
 rtl/aes_pkg.sv | 28 ++
 rtl/aes_sbox_byte.sv | 9 +
 rtl/aes_sbox_sub.sv | 35 +++
 tb/tb_aes_sbox_sub.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, state dimensions and the forward S-box table
package aes_pkg;
  localparam int DEF_NO_ROWS = 4;
  localparam int DEF_NO_COLS = 4;
  typedef logic [7:0] byte_t;
  typedef byte_t state_t [DEF_NO_ROWS][DEF_NO_COLS];
  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic byte_t sbox_lookup(input byte_t b);
    return SBOX[b];
  endfunction
endpackage

// File: rtl/aes_sbox_byte.sv
// aes_sbox_byte: combinational forward S-box substitution of one byte
module aes_sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);
  assign sbox_out = sbox_lookup(sbox_in);
endmodule

// File: rtl/aes_sbox_sub.sv
// aes_sbox_sub: registered masked SubBytes over a NO_ROWS x NO_COLS state matrix
module aes_sbox_sub
  import aes_pkg::*;
#(
  parameter int NO_ROWS = DEF_NO_ROWS,
  parameter int NO_COLS = DEF_NO_COLS
) (
  input  logic               aes_clk,
  input  logic               resetn,
  input  logic               sbox_en,
  input  logic [7:0]         sbox_ip_char_matrix [NO_ROWS][NO_COLS],
  input  logic [NO_ROWS-1:0] sbox_ip_char_row_mask,
  input  logic [NO_COLS-1:0] sbox_ip_char_col_mask,
  output logic               sbox_op_char_matrix_valid,
  output logic [7:0]         sbox_op_char_matrix [NO_ROWS][NO_COLS]
);
  logic [7:0] nxt [NO_ROWS][NO_COLS];
  for (genvar r = 0; r < NO_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NO_COLS; c++) begin : g_col
      logic [7:0] sub;
      aes_sbox_byte u_byte (.sbox_in(sbox_ip_char_matrix[r][c]), .sbox_out(sub));
      assign nxt[r][c] = (sbox_ip_char_row_mask[r] & sbox_ip_char_col_mask[c]) ? sub : sbox_ip_char_matrix[r][c];
    end
  end
  // Data only reloads on a request; it holds after valid drops for downstream use
  always_ff @(posedge aes_clk) begin
    if (!resetn) begin
      sbox_op_char_matrix_valid <= 1'b0;
      sbox_op_char_matrix <= '{default: '{default: 8'h00}};
    end else begin
      sbox_op_char_matrix_valid <= sbox_en;
      if (sbox_en) sbox_op_char_matrix <= nxt;
    end
  end
endmodule

// File: tb/tb_aes_sbox_sub.sv
// tb_aes_sbox_sub: directed checks of aes_sbox_sub against an arithmetic GF(2^8) S-box model
module tb_aes_sbox_sub;
  logic       aes_clk = 1'b0;
  logic       resetn;
  logic       sbox_en;
  logic [7:0] ip [4][4];
  logic [3:0] row_mask, col_mask;
  logic       valid;
  logic [7:0] op [4][4];
  int checks = 0;
  int failures = 0;

  aes_sbox_sub dut (
    .aes_clk(aes_clk),
    .resetn(resetn),
    .sbox_en(sbox_en),
    .sbox_ip_char_matrix(ip),
    .sbox_ip_char_row_mask(row_mask),
    .sbox_ip_char_col_mask(col_mask),
    .sbox_op_char_matrix_valid(valid),
    .sbox_op_char_matrix(op)
  );

  always #5 aes_clk = ~aes_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aes_clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ip[r][c] = v;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) followed by the FIPS-197 affine transform
  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  initial begin
    resetn = 1'b0;
    sbox_en = 1'b1;
    row_mask = 4'hf;
    col_mask = 4'hf;
    fill(8'h00);
    step();
    step();
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_b00", op[0][0], 8'h00);
    chk("rst_b33", op[3][3], 8'h00);
    resetn = 1'b1;
    step();
    chk("post_rst_valid", 8'(valid), 8'h01);
    chk("post_rst_b00", op[0][0], 8'h63);

    sbox_en = 1'b0;
    step();
    ip[0][0] = 8'h19;
    ip[1][1] = 8'h3d;
    ip[2][2] = 8'he3;
    ip[3][3] = 8'hbe;
    sbox_en = 1'b1;
    step();
    sbox_en = 1'b0;
    chk("full_valid", 8'(valid), 8'h01);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("full_b%0d%0d", r, c), op[r][c],
            r != c ? 8'h63 : r == 0 ? 8'hd4 : r == 1 ? 8'h27 : r == 2 ? 8'h11 : 8'hae);
    fill(8'h77);
    step();
    chk("full_valid_drop", 8'(valid), 8'h00);
    chk("full_hold_b00", op[0][0], 8'hd4);
    step();
    chk("full_hold_b33", op[3][3], 8'hae);

    fill(8'h53);
    row_mask = 4'b0010;
    col_mask = 4'b0100;
    sbox_en = 1'b1;
    step();
    sbox_en = 1'b0;
    chk("mask_valid", 8'(valid), 8'h01);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("mask_b%0d%0d", r, c), op[r][c], (r == 1 && c == 2) ? 8'hed : 8'h53);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) ip[r][c] = 8'(16 * r + c);
    row_mask = 4'h0;
    col_mask = 4'h0;
    sbox_en = 1'b1;
    step();
    chk("zero_valid", 8'(valid), 8'h01);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("zero_b%0d%0d", r, c), op[r][c], 8'(16 * r + c));

    row_mask = 4'hf;
    col_mask = 4'hf;
    fill(8'h00);
    step();
    chk("cont_b00_a", op[0][0], 8'h63);
    chk("cont_valid_a", 8'(valid), 8'h01);
    ip[0][0] = 8'hff;
    step();
    chk("cont_b00_b", op[0][0], 8'h16);
    chk("cont_valid_b", 8'(valid), 8'h01);

    for (int v = 0; v < 256; v++) begin
      ip[0][0] = 8'(v);
      step();
      chk($sformatf("sweep_%02h", v), op[0][0], ref_sbox(8'(v)));
      if (v == 8'h01) chk("spot_01", op[0][0], 8'h7c);
      if (v == 8'h10) chk("spot_10", op[0][0], 8'hca);
      if (v == 8'hc9) chk("spot_c9", op[0][0], 8'hdd);
      if (v == 8'hff) chk("spot_ff", op[0][0], 8'h16);
    end

    resetn = 1'b0;
    step();
    chk("abort_valid", 8'(valid), 8'h00);
    chk("abort_b00", op[0][0], 8'h00);
    resetn = 1'b1;
    sbox_en = 1'b0;
    step();
    chk("abort_idle_valid", 8'(valid), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
